// File: rtl/exe_mem_pipe_reg.sv
// exe_mem_pipe_reg: EXE->MEM pipeline register with valid, stall/flush and an overflow trap FSM.
// Define EXE_MEM_EPC_EN to add mem_epc/mem_cause capture of the trapping instruction.
module exe_mem_pipe_reg #(
    parameter int DATA_W   = 32,
    parameter int RN_W     = 5,
    parameter int PC_W     = 32,
    parameter int CAUSE_W  = 5,
    parameter int OV_CAUSE = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              exc_ack,
    input  logic              exe_valid,
    input  logic              exe_wreg,
    input  logic              exe_m2reg,
    input  logic              exe_wmem,
    input  logic              exe_uns,
    input  logic              exe_half,
    input  logic              exe_byte,
    input  logic [RN_W-1:0]   exe_rn,
    input  logic [DATA_W-1:0] exe_alu,
    input  logic [DATA_W-1:0] exe_b,
    input  logic              exe_overflow,
    input  logic              exe_ov_trap,
    input  logic [PC_W-1:0]   exe_pc,
    output logic              mem_valid,
    output logic              mem_wreg,
    output logic              mem_m2reg,
    output logic              mem_wmem,
    output logic              mem_uns,
    output logic              mem_half,
    output logic              mem_byte,
    output logic [RN_W-1:0]   mem_rn,
    output logic [DATA_W-1:0] mem_alu,
    output logic [DATA_W-1:0] mem_b,
`ifdef EXE_MEM_EPC_EN
    output logic [CAUSE_W-1:0] mem_cause,
    output logic [PC_W-1:0]    mem_epc,
`endif
    output logic              mem_exc
);
    typedef enum logic {RUN, TRAP} state_t;
    state_t state, state_nxt;
    logic trap_in, ack, load, capture, pass;
    always_comb begin
        trap_in   = exe_valid & exe_overflow & exe_ov_trap;
        ack       = (state == TRAP) & exc_ack;
        load      = ~ack & ~flush & ~stall;
        capture   = load & (state == RUN) & trap_in;
        // only a non-trapping instruction in RUN keeps its valid and write enables
        pass      = (state == RUN) & ~trap_in;
        state_nxt = ack ? RUN : capture ? TRAP : state;
    end
    always_ff @(posedge clk)
        state <= rst ? RUN : state_nxt;
    assign mem_exc = (state == TRAP);
    always_ff @(posedge clk) begin
        if (rst) begin
            {mem_valid, mem_wreg, mem_m2reg, mem_wmem} <= '0;
        end else if (ack | flush) begin
            {mem_valid, mem_wreg, mem_m2reg, mem_wmem} <= '0;
        end else if (load) begin
            mem_valid <= exe_valid & pass;
            mem_wreg  <= exe_wreg & pass;
            mem_m2reg <= exe_m2reg & pass;
            mem_wmem  <= exe_wmem & pass;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {mem_uns, mem_half, mem_byte} <= '0;
            mem_rn  <= '0;
            mem_alu <= '0;
            mem_b   <= '0;
        end else if (load) begin
            {mem_uns, mem_half, mem_byte} <= {exe_uns, exe_half, exe_byte};
            mem_rn  <= exe_rn;
            mem_alu <= exe_alu;
            mem_b   <= exe_b;
        end
    end
`ifdef EXE_MEM_EPC_EN
    always_ff @(posedge clk) begin
        if (rst | ack) begin
            mem_epc   <= '0;
            mem_cause <= '0;
        end else if (capture) begin
            mem_epc   <= exe_pc;
            mem_cause <= CAUSE_W'(OV_CAUSE);
        end
    end
`endif
endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// tb_exe_mem_pipe_reg: directed bench with a per-cycle reference model and literal spot checks.
// Honours EXE_MEM_EPC_EN the same way the design does.
module tb_exe_mem_pipe_reg;
    logic clk = 0, rst, stall, flush, exc_ack;
    logic exe_valid, exe_wreg, exe_m2reg, exe_wmem, exe_uns, exe_half, exe_byte;
    logic [4:0] exe_rn;
    logic [31:0] exe_alu, exe_b, exe_pc;
    logic exe_overflow, exe_ov_trap;
    logic mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_uns, mem_half, mem_byte, mem_exc;
    logic [4:0] mem_rn;
    logic [31:0] mem_alu, mem_b;
`ifdef EXE_MEM_EPC_EN
    logic [4:0] mem_cause;
    logic [31:0] mem_epc;
`endif
    int total = 0, bad = 0;
    bit started = 0;

    exe_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .exe_valid(exe_valid), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem),
        .exe_uns(exe_uns), .exe_half(exe_half), .exe_byte(exe_byte), .exe_rn(exe_rn),
        .exe_alu(exe_alu), .exe_b(exe_b), .exe_overflow(exe_overflow), .exe_ov_trap(exe_ov_trap),
        .exe_pc(exe_pc), .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .mem_wmem(mem_wmem), .mem_uns(mem_uns), .mem_half(mem_half), .mem_byte(mem_byte),
        .mem_rn(mem_rn), .mem_alu(mem_alu), .mem_b(mem_b),
`ifdef EXE_MEM_EPC_EN
        .mem_cause(mem_cause), .mem_epc(mem_epc),
`endif
        .mem_exc(mem_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: what MEM must hold after each edge
    typedef struct {
        bit v, wreg, m2reg, wmem, uns, half, byt, trap;
        logic [4:0] rn, cause;
        logic [31:0] alu, b, epc;
    } mstate_t;
    mstate_t m;

    always @(posedge clk) begin
        if (rst) begin
            m = '{default: 0};
            started = 1;
        end else if (m.trap && exc_ack) begin
            m.trap = 0; m.epc = 0; m.cause = 0;
            {m.v, m.wreg, m.m2reg, m.wmem} = 0;
        end else if (flush) begin
            {m.v, m.wreg, m.m2reg, m.wmem} = 0;
        end else if (!stall) begin
            {m.uns, m.half, m.byt, m.rn, m.alu, m.b} = {exe_uns, exe_half, exe_byte, exe_rn, exe_alu, exe_b};
            if (m.trap) begin
                {m.v, m.wreg, m.m2reg, m.wmem} = 0;
            end else if (exe_valid && exe_overflow && exe_ov_trap) begin
                {m.v, m.wreg, m.m2reg, m.wmem} = 0;
                m.trap = 1; m.epc = exe_pc; m.cause = 12;
            end else begin
                {m.v, m.wreg, m.m2reg, m.wmem} = {exe_valid, exe_wreg, exe_m2reg, exe_wmem};
            end
        end
        #1;
        if (started) begin
            chk("valid", 32'(mem_valid), 32'(m.v));
            chk("wreg", 32'(mem_wreg), 32'(m.wreg));
            chk("m2reg", 32'(mem_m2reg), 32'(m.m2reg));
            chk("wmem", 32'(mem_wmem), 32'(m.wmem));
            chk("size", 32'({mem_uns, mem_half, mem_byte}), 32'({m.uns, m.half, m.byt}));
            chk("rn", 32'(mem_rn), 32'(m.rn));
            chk("alu", mem_alu, m.alu);
            chk("b", mem_b, m.b);
            chk("exc", 32'(mem_exc), 32'(m.trap));
`ifdef EXE_MEM_EPC_EN
            chk("epc", mem_epc, m.epc);
            chk("cause", 32'(mem_cause), 32'(m.cause));
`endif
        end
    end

    task automatic instr(input bit v, input bit w, input logic [4:0] rn, input logic [31:0] alu,
                         input bit ov, input bit ot, input logic [31:0] pc);
        {exe_valid, exe_wreg, exe_rn, exe_alu, exe_overflow, exe_ov_trap, exe_pc} = {v, w, rn, alu, ov, ot, pc};
        exe_m2reg = 0; exe_wmem = w; exe_b = alu ^ 32'hFFFF_0000;
        {exe_uns, exe_half, exe_byte} = 3'(alu);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        {rst, stall, flush, exc_ack} = 0;
        instr(0, 0, 0, 0, 0, 0, 0);
        #2;
        // 1: reset with random inputs
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            instr(1'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
            {stall, flush, exc_ack} = 3'($urandom);
            tick();
        end
        chk("rst_valid", 32'(mem_valid), 0);
        chk("rst_exc", 32'(mem_exc), 0);
        chk("rst_alu", mem_alu, 0);
        rst = 0; {stall, flush, exc_ack} = 0;
        // 2: normal load
        instr(1, 1, 5, 32'h1234, 0, 0, 32'h10); tick();
        chk("ld_valid", 32'(mem_valid), 1);
        chk("ld_rn", 32'(mem_rn), 5);
        chk("ld_alu", mem_alu, 32'h1234);
        chk("ld_wreg", 32'(mem_wreg), 1);
        // 3: overflow trap, bubbles while trapped, then ack
        instr(1, 1, 7, 32'h7FFF_FFFF, 1, 1, 32'h40); tick();
        chk("tr_wreg", 32'(mem_wreg), 0);
        chk("tr_valid", 32'(mem_valid), 0);
        chk("tr_exc", 32'(mem_exc), 1);
`ifdef EXE_MEM_EPC_EN
        chk("tr_epc", mem_epc, 32'h40);
        chk("tr_cause", 32'(mem_cause), 12);
`endif
        for (int i = 0; i < 3; i++) begin
            instr(1, 1, 5'(i + 1), 32'(i * 16), i == 1, i == 1, 32'h44 + 32'(i * 4)); tick();
            chk("bub_valid", 32'(mem_valid), 0);
        end
        flush = 1; tick(); flush = 0;
        chk("tr_flush_exc", 32'(mem_exc), 1);
        exc_ack = 1; instr(1, 1, 9, 32'h99, 0, 0, 32'h50); tick(); exc_ack = 0;
        chk("ack_exc", 32'(mem_exc), 0);
        chk("ack_valid", 32'(mem_valid), 0);
        instr(1, 1, 10, 32'hAA, 0, 0, 32'h54); tick();
        chk("post_valid", 32'(mem_valid), 1);
        chk("post_alu", mem_alu, 32'hAA);
        // ack while running is ignored
        exc_ack = 1; instr(1, 0, 11, 32'hBB, 0, 0, 32'h58); tick(); exc_ack = 0;
        chk("ack_run_valid", 32'(mem_valid), 1);
        // 4: overflow without trap enable
        instr(1, 1, 12, 32'h8000_0000, 1, 0, 32'h5C); tick();
        chk("addu_wreg", 32'(mem_wreg), 1);
        chk("addu_exc", 32'(mem_exc), 0);
        // 5: stall holds, trap_in ignored while stalled; stall+flush gives a bubble
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            instr(1, 1, 5'(20 + i), 32'h5000 + 32'(i), i == 2, i == 2, 32'h60); tick();
            chk("stall_alu", mem_alu, 32'h8000_0000);
        end
        chk("stall_exc", 32'(mem_exc), 0);
        flush = 1; tick(); {stall, flush} = 0;
        chk("sf_valid", 32'(mem_valid), 0);
        chk("sf_alu", mem_alu, 32'h8000_0000);
        // 6: ack with reset in TRAP; ack with trap_in
        instr(1, 1, 3, 32'h33, 1, 1, 32'h70); tick();
        rst = 1; exc_ack = 1; tick(); {rst, exc_ack} = 0;
        chk("ackrst_exc", 32'(mem_exc), 0);
        chk("ackrst_alu", mem_alu, 0);
        instr(1, 1, 4, 32'h44, 1, 1, 32'h74); tick();
        exc_ack = 1; instr(1, 1, 6, 32'h66, 1, 1, 32'h78); tick(); exc_ack = 0;
        chk("acktr_exc", 32'(mem_exc), 0);
        chk("acktr_valid", 32'(mem_valid), 0);
        instr(1, 0, 8, 32'h88, 0, 0, 32'h7C); tick();
        chk("acktr_next_exc", 32'(mem_exc), 0);
        // mixed stream against the model
        for (int i = 0; i < 150; i++) begin
            instr(1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3) == 0, 1'($urandom), $urandom);
            exe_m2reg = 1'($urandom);
            stall = $urandom_range(0, 4) == 0; flush = $urandom_range(0, 7) == 0;
            exc_ack = $urandom_range(0, 3) == 0; rst = $urandom_range(0, 40) == 0;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
